// File: rtl/cell_particle_streamer_if.sv
// Stream-side bundle for cell_particle_streamer: the RAM read port and the
// valid/ready particle output channel towards the force pipeline.
interface cell_particle_streamer_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_rden;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_data;
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport master (
        output ram_address, ram_rden, ram_wren, ram_data,
        input  ram_q,
        output out_valid, out_data, out_index, out_last,
        input  out_ready
    );

    modport slave (
        input  ram_address, ram_rden, ram_wren, ram_data,
        output ram_q,
        input  out_valid, out_data, out_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/cell_particle_streamer.sv
// Reads the particle count at address 0 of a cell RAM, then streams addresses 1..count
// through a credit-tracked FIFO. Optional count clamping: CELL_STREAM_CNT_CHECK_EN.
module cell_particle_streamer #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  start,
    cell_particle_streamer_if.master bus,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  busy,
    output logic                  done
`ifdef CELL_STREAM_CNT_CHECK_EN
    ,
    output logic                  cnt_err
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FIN} state_t;

    state_t                state;
    logic [WW-1:0]         wait_cnt;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         occ;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_index [FIFO_DEPTH];
    logic                  fifo_last  [FIFO_DEPTH];
    logic                  tag_sr     [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_sr    [RD_LATENCY];

    logic                  push;
    logic                  pop;
    logic                  wait_done;
    logic                  issue;
    logic                  credit_ok;
    logic [CW:0]           credit_used;
    logic [ADDR_WIDTH-1:0] raw_count;
    logic [ADDR_WIDTH-1:0] count_sel;

    assign bus.ram_wren  = 1'b0;
    assign bus.ram_data  = '0;
    assign bus.out_valid = (occ != '0);
    assign bus.out_data  = fifo_data[rd_ptr];
    assign bus.out_index = fifo_index[rd_ptr];
    assign bus.out_last  = fifo_last[rd_ptr];

    assign push      = tag_sr[RD_LATENCY-1];
    assign pop       = bus.out_valid && bus.out_ready;
    assign raw_count = bus.ram_q[ADDR_WIDTH-1:0];
    assign wait_done = (wait_cnt == WW'(RD_LATENCY - 1));

`ifdef CELL_STREAM_CNT_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    assign count_sel = (raw_count > MAX_COUNT) ? MAX_COUNT : raw_count;
`else
    assign count_sel = raw_count;
`endif

    // A word leaving the FIFO this cycle frees its slot for a read issued this cycle.
    assign credit_used = {1'b0, occ} + {1'b0, inflight} - {{CW{1'b0}}, pop};
    assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);
    assign issue       = ((state == WAIT_CNT) && wait_done && (count_sel != '0)) ||
                         ((state == STREAM) && credit_ok);

    always_ff @(posedge clock) begin
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            next_addr       <= '0;
            inflight        <= '0;
            occ             <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            particle_count  <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            bus.ram_address <= '0;
            bus.ram_rden    <= 1'b0;
`ifdef CELL_STREAM_CNT_CHECK_EN
            cnt_err         <= 1'b0;
`endif
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i]  <= '0;
                fifo_index[i] <= '0;
                fifo_last[i]  <= 1'b0;
            end
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                tag_sr[i]  <= 1'b0;
                addr_sr[i] <= '0;
            end
        end else begin
            done         <= 1'b0;
            bus.ram_rden <= 1'b0;

            // Only data reads are tagged; the count read happens in RD_CNT.
            tag_sr[0]  <= bus.ram_rden && (state != RD_CNT);
            addr_sr[0] <= bus.ram_address;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_sr[i]  <= tag_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end

            inflight <= inflight + CW'(issue) - CW'(push);
            occ      <= occ + CW'(push) - CW'(pop);
            if (push) begin
                fifo_data[wr_ptr]  <= bus.ram_q;
                fifo_index[wr_ptr] <= addr_sr[RD_LATENCY-1];
                fifo_last[wr_ptr]  <= (addr_sr[RD_LATENCY-1] == particle_count);
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= RD_CNT;
                        busy            <= 1'b1;
                        bus.ram_rden    <= 1'b1;
                        bus.ram_address <= '0;
`ifdef CELL_STREAM_CNT_CHECK_EN
                        cnt_err         <= 1'b0;
`endif
                    end
                end
                RD_CNT: begin
                    state    <= WAIT_CNT;
                    wait_cnt <= '0;
                end
                WAIT_CNT: begin
                    if (wait_done) begin
                        particle_count <= count_sel;
`ifdef CELL_STREAM_CNT_CHECK_EN
                        if (raw_count > MAX_COUNT) cnt_err <= 1'b1;
`endif
                        if (count_sel == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            // Address 1 is issued on the exit edge so the first word
                            // arrives 3+2*RD_LATENCY cycles after start.
                            bus.ram_rden    <= 1'b1;
                            bus.ram_address <= ADDR_WIDTH'(1);
                            next_addr       <= (count_sel == ADDR_WIDTH'(1)) ? ADDR_WIDTH'(1)
                                                                             : ADDR_WIDTH'(2);
                            state           <= (count_sel == ADDR_WIDTH'(1)) ? DRAIN : STREAM;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (credit_ok) begin
                        bus.ram_rden    <= 1'b1;
                        bus.ram_address <= next_addr;
                        if (next_addr == particle_count) begin
                            state <= DRAIN;
                        end else begin
                            next_addr <= next_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((inflight == '0) && (occ == '0)) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_particle_streamer.sv
// Scoreboard bench for cell_particle_streamer with a 2-cycle-latency RAM model.
// Expected words are queued at stimulus time and popped on each output handshake.
module tb_cell_particle_streamer;
    localparam int DW = 96;
    localparam int AW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] index;
        logic          last;
    } exp_t;

    logic          clock = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] particle_count;
    logic          busy;
    logic          done;
`ifdef CELL_STREAM_CNT_CHECK_EN
    logic          cnt_err;
`endif

    cell_particle_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cell_particle_streamer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(220), .RD_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .rst(rst),
        .start(start),
        .bus(bus),
        .particle_count(particle_count),
        .busy(busy),
        .done(done)
`ifdef CELL_STREAM_CNT_CHECK_EN
        ,
        .cnt_err(cnt_err)
`endif
    );

    always #5 clock = ~clock;

    logic [DW-1:0] ram [0:255];
    logic [DW-1:0] ram_pipe;
    always @(posedge clock) begin
        ram_pipe  <= ram[bus.ram_address];
        bus.ram_q <= ram_pipe;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   reads, words, dones, first_valid, c0;
    exp_t sb[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic          stalled = 1'b0;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_index;
    logic          held_last;

    always @(negedge clock) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (bus.ram_rden) reads++;
            if (done) dones++;
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (stalled) begin
                check("hold_valid", 128'(bus.out_valid), 128'(1));
                check("hold_data",  128'(bus.out_data),  128'(held_data));
                check("hold_index", 128'(bus.out_index), 128'(held_index));
                check("hold_last",  128'(bus.out_last),  128'(held_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                words++;
                if (sb.size() == 0) begin
                    check("extra_word", 128'(bus.out_index), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data",  128'(bus.out_data),  128'(e.data));
                    check("index", 128'(bus.out_index), 128'(e.index));
                    check("last",  128'(bus.out_last),  128'(e.last));
                end
            end
            stalled    = bus.out_valid && !bus.out_ready;
            held_data  = bus.out_data;
            held_index = bus.out_index;
            held_last  = bus.out_last;
        end
    end

    task automatic load_cell(input int cnt_word, input int n);
        ram[0] = {$urandom, $urandom, 24'h0, 8'(cnt_word)};
        for (int i = 1; i <= n; i++) begin
            ram[i] = {$urandom, $urandom, $urandom};
            sb.push_back('{ram[i], AW'(i), (i == n)});
        end
    endtask

    // mode 0: ready high, 1: ready pattern 1-0-0-1, 2: extra start mid-stream
    task automatic run_stream(input int cnt_word, input int n, input int mode);
        logic [3:0] pat = 4'b1001;
        int k = 0;
        load_cell(cnt_word, n);
        reads = 0; words = 0; dones = 0; first_valid = -1;
        @(posedge clock); #1 start = 1'b1; c0 = cyc;
        @(posedge clock); #1 start = 1'b0;
        while (dones == 0 && k < 2000) begin
            bus.out_ready = (mode == 1) ? pat[k % 4] : 1'b1;
            start = (mode == 2 && (k == 3 || k == 6));
            @(posedge clock); #1;
            k++;
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        check("done_seen",   128'(dones != 0), 128'(1));
        check("busy_after",  128'(busy), 128'(0));
        check("done_single", 128'(done), 128'(0));
        check("done_count",  128'(dones), 128'(1));
        check("word_count",  128'(words), 128'(n));
        check("sb_empty",    128'(sb.size()), 128'(0));
        check("pcount",      128'(particle_count), 128'(n));
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;

        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_busy",  128'(busy), 128'(0));
        check("rst_done",  128'(done), 128'(0));
        check("rst_rden",  128'(bus.ram_rden), 128'(0));
        check("rst_addr",  128'(bus.ram_address), 128'(0));
        check("rst_pcnt",  128'(particle_count), 128'(0));
        check("rst_data",  128'(bus.out_data), 128'(0));
        check("rst_last",  128'(bus.out_last), 128'(0));
        check("wren_zero", 128'({bus.ram_wren, bus.ram_data}), 128'(0));

        run_stream(3, 3, 0);
        check("first_latency", 128'(first_valid - c0), 128'(7));

        run_stream(0, 0, 0);
        check("cnt0_reads", 128'(reads), 128'(1));
        check("cnt0_novalid", 128'(first_valid < 0), 128'(1));

        run_stream(10, 10, 1);
        run_stream(5, 5, 2);
        run_stream(1, 1, 0);

        // Abort after two of six words, then restream the same cell.
        load_cell(6, 6);
        words = 0; dones = 0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        k = 0;
        while (words < 2 && k < 200) begin
            @(posedge clock); #1;
            k++;
        end
        check("abort_words", 128'(words), 128'(2));
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clock); #1 rst = 1'b0;
        check("abort_valid", 128'(bus.out_valid), 128'(0));
        check("abort_busy",  128'(busy), 128'(0));
        check("abort_rden",  128'(bus.ram_rden), 128'(0));
        check("abort_pcnt",  128'(particle_count), 128'(0));
        check("abort_index", 128'(bus.out_index), 128'(0));
        sb.delete();
        run_stream(6, 6, 0);

`ifdef CELL_STREAM_CNT_CHECK_EN
        run_stream(250, 219, 0);
        check("cnt_err", 128'(cnt_err), 128'(1));
`else
        run_stream(250, 250, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cell_particle_streamer.md
Name: cell_particle_streamer

Overview:
- Read-side sequencer placed directly downstream of one per-cell position RAM. The RAM is single port, has 2-cycle read latency, and stores the particle count at address 0.
- On a start request it reads the count word, then streams particle positions from addresses 1..count to the force-pipeline consumer over a valid/ready interface.
- An internal credit-tracked FIFO absorbs the RAM read latency, so backpressure never drops a word.

Parameters:
- DATA_WIDTH, 96, position word width {posz, posy, posx}, 32 bits each.
- ADDR_WIDTH, 8, RAM address width.
- PARTICLE_NUM, 220, RAM depth in words. Maximum legal count is PARTICLE_NUM-1.
- RD_LATENCY, 2, RAM address-to-q latency in cycles.
- FIFO_DEPTH, 4, output buffer entries. Must be >= RD_LATENCY+1 for full throughput.

Ports:
- clock  in  1  single clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to stream the cell. Sampled only in IDLE.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_rden  out  1  to RAM rden.
- ram_wren  out  1  to RAM wren. Constant 0.
- ram_data  out  DATA_WIDTH  to RAM data. Constant 0.
- ram_q  in  DATA_WIDTH  from RAM q.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  DATA_WIDTH  particle position.
- out_index  out  ADDR_WIDTH  RAM address of the word, 1..count.
- out_last  out  1  asserted with the final particle word.
- particle_count  out  ADDR_WIDTH  latched count. Valid from the WAIT_CNT exit until the next start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the stream completes.
- cnt_err  out  1  count out of range. Present only with the optional feature.

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, in-flight counter 0. Reset has priority over every other event, including mid-stream; RAM reads in flight when reset is applied are discarded.
- ram_address and ram_rden are registered. A read issued in cycle N returns on ram_q in cycle N+RD_LATENCY. A RD_LATENCY-deep valid shift register tags returning words.
- States:
  - IDLE: if start, go to RD_CNT. Otherwise hold.
  - RD_CNT: drive address 0, rden=1 for exactly one cycle, then go to WAIT_CNT.
  - WAIT_CNT: wait RD_LATENCY cycles. Latch count = ram_q[ADDR_WIDTH-1:0]. If count==0, go to FIN; otherwise set next_addr=1 and go to STREAM.
  - STREAM: issue a read (rden=1, address=next_addr, next_addr+1) only in a cycle where fifo_occupancy + inflight < FIFO_DEPTH. When the read of address count has been issued, go to DRAIN.
  - DRAIN: no new reads. Wait until inflight==0, the FIFO is empty and the last word has been accepted, then go to FIN.
  - FIN: done=1 for one cycle, then go to IDLE.
- A start pulse in any state other than IDLE is ignored. There is no queuing.
- Returning tagged words are pushed into the FIFO together with their address. Credit accounting guarantees the FIFO never overflows.
- Output side:
  - out_valid = FIFO not empty. out_data, out_index and out_last come from the FIFO head.
  - Pop occurs on out_valid && out_ready.
  - A push and a pop in the same cycle keep occupancy unchanged.
  - out_data, out_index and out_last stay stable while out_valid && !out_ready.
- Throughput: with out_ready held high, one word per cycle after a fill latency. First out_valid appears 3+2*RD_LATENCY cycles after start (7 cycles at defaults).
- out_last is set for the entry whose address equals count.
- Counters are ADDR_WIDTH wide. next_addr never exceeds count, so there is no wrap.

Optional Feature:
- Macro: CELL_STREAM_CNT_CHECK_EN.
- Defined:
  - A latched count > PARTICLE_NUM-1 is clamped to PARTICLE_NUM-1.
  - cnt_err is set and held high until the next start or reset.
- Undefined:
  - The count is used as latched, truncated to ADDR_WIDTH.
  - The cnt_err port is absent.

Test Plan:
- Count=3, data words A,B,C at addresses 1..3, out_ready=1 -> out_valid high for 3 consecutive cycles carrying A/1, B/2, C/3; out_last on C; done pulse follows; busy low one cycle after done.
- Count=0 -> no out_valid; exactly one RAM read (address 0); done pulses 1 cycle after WAIT_CNT.
- Count=10, out_ready toggling 1-0-0-1 -> all 10 words delivered in order with no loss or duplication; occupancy never exceeds 4; outputs stable while stalled.
- start re-pulsed during STREAM of count=5 -> ignored; exactly 5 words and one done pulse.
- rst asserted mid-stream after 2 of 6 words -> next cycle all outputs 0, state IDLE; a new start streams all 6 words correctly, with no stale words from the aborted stream.
- With CELL_STREAM_CNT_CHECK_EN, count word=250 -> particle_count=219, cnt_err=1, 219 words streamed. Without the macro -> 250 words requested.
